// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : 8N1 UART receive sequencer with 16x oversampling and valid/ready out
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl #(
  parameter int OSR    = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic [2:0]        select,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy,
  output logic              bit_tick
);

  localparam int c_TICK_W = $clog2(OSR);
  localparam int c_BIT_W  = $clog2(DATA_W + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic                r_sync1, r_sync2, r_prev;
  logic [1:0]          r_state;
  logic [8:0]          r_div, r_div_cnt;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0]   r_shift, r_data;
  logic                r_stop_bit, r_done, r_valid, r_ferr, r_ovr;

  logic [8:0] w_div_sel;
  logic       w_tick, w_start_pt, w_bit_pt, w_fall;

  always_comb begin
    w_div_sel = 9'd27;
    case (select)
      3'd0:    w_div_sel = 9'd326;
      3'd1:    w_div_sel = 9'd163;
      3'd2:    w_div_sel = 9'd81;
      3'd3:    w_div_sel = 9'd54;
      default: w_div_sel = 9'd27;
    endcase
  end

  assign w_fall     = r_prev & ~r_sync2;
  assign w_tick     = (r_state != c_IDLE) && (r_div_cnt == r_div - 9'd1);
  assign w_start_pt = w_tick && (r_state == c_START) &&
                      (r_tick_cnt == c_TICK_W'(OSR/2 - 1));
  assign w_bit_pt   = w_tick && ((r_state == c_DATA) || (r_state == c_STOP)) &&
                      (r_tick_cnt == c_TICK_W'(OSR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_div      <= 9'd27;
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_stop_bit <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == c_STOP) && w_bit_pt;
      // Counters idle at zero so every frame starts its timing fresh.
      if (r_state == c_IDLE) begin
        r_div_cnt  <= '0;
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_div_cnt  <= '0;
        r_tick_cnt <= w_start_pt ? '0 : r_tick_cnt + 1'b1;
      end else begin
        r_div_cnt  <= r_div_cnt + 9'd1;
      end
      case (r_state)
        c_IDLE: begin
          if (w_fall) begin
            r_state   <= c_START;
            r_div     <= w_div_sel;
            r_bit_cnt <= '0;
          end
        end
        c_START: begin
          if (w_start_pt) r_state <= r_sync2 ? c_IDLE : c_DATA;
        end
        c_DATA: begin
          if (w_bit_pt) begin
            r_shift   <= {r_sync2, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_BIT_W'(DATA_W - 1)) r_state <= c_STOP;
          end
        end
        default: begin
          // Leave on the stop sample so a back-to-back start edge is seen.
          if (w_bit_pt) begin
            r_stop_bit <= r_sync2;
            r_state    <= c_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (r_done) begin
      if (!r_valid || ready) begin
        r_data  <= r_shift;
        r_ferr  <= ~r_stop_bit;
        r_valid <= 1'b1;
        if (r_valid) r_ovr <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != c_IDLE);
  assign bit_tick  = w_start_pt | w_bit_pt;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Brief   : Directed table-driven bench for uart_rx_ctrl
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b1;
  logic [2:0] select = 3'd4;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b1;
  logic       frame_err, overrun, busy, bit_tick;

  uart_rx_ctrl #(.OSR(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .select(select),
    .data(data), .valid(valid), .ready(ready), .frame_err(frame_err),
    .overrun(overrun), .busy(busy), .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] byte_v;
    logic       stopb;
    logic [7:0] exp_data;
    logic       exp_ferr;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;
  int t_valid = -1;
  int n_ticks = 0;
  logic last_valid = 1'b0;
  logic [8:0] rxq[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid && ready) rxq.push_back({frame_err, data});
  end

  always @(negedge clk) begin
    if (bit_tick) n_ticks <= n_ticks + 1;
    if (valid && !last_valid && t_valid < 0) t_valid <= cyc;
    last_valid <= valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int div_of(input logic [2:0] s);
    case (s)
      3'd0: return 326;
      3'd1: return 163;
      3'd2: return 81;
      3'd3: return 54;
      default: return 27;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [2:0] s, input logic [7:0] b, input logic stopb);
    int bp;
    bp = 16 * div_of(s);
    @(negedge clk);
    select  = s;
    din     = 1'b0;
    t_start = cyc;
    t_valid = -1;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (bp) @(negedge clk);
    end
    din = stopb;
    repeat (bp) @(negedge clk);
    din = 1'b1;
  endtask

  initial begin
    // Latency from driving the start bit to valid visible on a falling edge:
    // 2 sync flops + edge register, 8 ticks to mid-start, 9 bit periods to
    // mid-stop, one cycle to complete: 4 + 152*div.
    vecs[0] = '{3'd4, 8'h55, 1'b1, 8'h55, 1'b0, 4108};
    vecs[1] = '{3'd7, 8'h00, 1'b1, 8'h00, 1'b0, 4108};
    vecs[2] = '{3'd3, 8'h96, 1'b1, 8'h96, 1'b0, 8212};
    vecs[3] = '{3'd2, 8'hC7, 1'b1, 8'hC7, 1'b0, 12316};
    vecs[4] = '{3'd6, 8'h3C, 1'b0, 8'h3C, 1'b1, 4108};
    vecs[5] = '{3'd4, 8'h01, 1'b1, 8'h01, 1'b0, 4108};

    idle(3);
    chk("reset_data", data, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    idle(5);

    for (int v = 0; v < 6; v++) begin
      rxq.delete();
      n_ticks = 0;
      send_frame(vecs[v].sel, vecs[v].byte_v, vecs[v].stopb);
      idle(20);
      chk($sformatf("v%0d_count", v), rxq.size(), 1);
      if (rxq.size() > 0) begin
        chk($sformatf("v%0d_data", v), rxq[0][7:0], vecs[v].exp_data);
        chk($sformatf("v%0d_ferr", v), rxq[0][8], vecs[v].exp_ferr);
      end
      chk($sformatf("v%0d_latency", v), t_valid - t_start, vecs[v].exp_lat);
      chk($sformatf("v%0d_ticks", v), n_ticks, 10);
      chk($sformatf("v%0d_valid_low", v), valid, 0);
      chk($sformatf("v%0d_busy", v), busy, 0);
    end

    // Back-to-back frames, stop bit exactly one bit long.
    rxq.delete();
    send_frame(3'd4, 8'hA3, 1'b1);
    send_frame(3'd4, 8'h0F, 1'b1);
    idle(20);
    chk("b2b_count", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk("b2b_first", rxq[0][7:0], 8'hA3);
      chk("b2b_second", rxq[1][7:0], 8'h0F);
    end
    chk("b2b_overrun", overrun, 0);

    // Short low glitch on an idle line.
    rxq.delete();
    @(negedge clk);
    select = 3'd4;
    din = 1'b0;
    idle(80);
    din = 1'b1;
    idle(10);
    chk("glitch_busy_mid", busy, 1);
    idle(300);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_valid", valid, 0);
    chk("glitch_count", rxq.size(), 0);

    // Overrun with consumer stalled, then a single accept.
    ready = 1'b0;
    send_frame(3'd4, 8'h11, 1'b1);
    idle(20);
    chk("ovr_first_valid", valid, 1);
    chk("ovr_first_flag", overrun, 0);
    send_frame(3'd4, 8'h22, 1'b1);
    idle(20);
    chk("ovr_data_kept", data, 8'h11);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", valid, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("ovr_accept_valid", valid, 0);
    chk("ovr_accept_flag", overrun, 0);

    // Reset in the middle of a frame, with a byte already held.
    send_frame(3'd4, 8'h5A, 1'b1);
    idle(20);
    chk("prerst_valid", valid, 1);
    fork
      send_frame(3'd4, 8'hFF, 1'b1);
      begin
        idle(1500);
        rst_n = 1'b0;
        #1;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", bit_tick, 0);
        idle(3);
        rst_n = 1'b1;
      end
    join
    idle(20);
    chk("postrst_valid", valid, 0);
    ready = 1'b1;
    rxq.delete();
    send_frame(3'd4, 8'h81, 1'b1);
    idle(20);
    chk("postrst_count", rxq.size(), 1);
    if (rxq.size() > 0) chk("postrst_data", rxq[0][7:0], 8'h81);

    // Break: line held low through the stop bit and beyond.
    rxq.delete();
    @(negedge clk);
    select = 3'd4;
    din = 1'b0;
    idle(4400);
    chk("break_count", rxq.size(), 1);
    if (rxq.size() > 0) begin
      chk("break_data", rxq[0][7:0], 0);
      chk("break_ferr", rxq[0][8], 1);
    end
    idle(600);
    chk("break_no_retrigger", busy, 0);
    din = 1'b1;
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
